// File: rtl/store_unit.sv
// store_unit: performs byte/half/word stores on a word-wide sync RAM.
// Sub-word stores use read-modify-write; misaligned or illegal sizes
// are rejected with a done+err pulse.
// Ports: clk, rst (sync, active-high); req_valid/req_ready/req_addr/
// req_wdata/req_size request side; done/err completion pulses;
// ram_addr/ram_re/ram_rdata/ram_we/ram_wdata RAM side.
// Optional macro STORE_UNIT_BE_EN: adds ram_be[3:0] byte enables and
// replaces read-modify-write with a single masked write.
module store_unit #(
  parameter int RAM_AW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  output logic              done,
  output logic              err,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_re,
  input  logic [31:0]       ram_rdata,
  output logic              ram_we,
`ifdef STORE_UNIT_BE_EN
  output logic [3:0]        ram_be,
`endif
  output logic [31:0]       ram_wdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_MERGE,
    S_WRITE,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [RAM_AW-1:0] waddr_q, waddr_d;
  logic [1:0]        off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic [31:0]       data_q, data_d;

  logic        legal;
  logic [31:0] merged;

  // Upper address bits wrap; they are intentionally not decoded.
  logic unused_bits;
`ifdef STORE_UNIT_BE_EN
  assign unused_bits = ^{req_addr[31:RAM_AW+2], ram_rdata};
`else
  assign unused_bits = ^req_addr[31:RAM_AW+2];
`endif

  always_comb begin
    legal = 1'b1;
    unique case (req_size)
      2'b01:   legal = ~req_addr[0];
      2'b10:   legal = (req_addr[1:0] == 2'b00);
      2'b11:   legal = 1'b0;
      default: legal = 1'b1;
    endcase
  end

  // Insert the stored lane(s) into the word read back from RAM.
  always_comb begin
    merged = ram_rdata;
    if (size_q == 2'b00) begin
      merged[{off_q, 3'b000} +: 8] = data_q[7:0];
    end else begin
      merged[{off_q[1], 4'b0000} +: 16] = data_q[15:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    waddr_d   = waddr_q;
    off_d     = off_q;
    size_d    = size_q;
    data_d    = data_q;
    req_ready = 1'b0;
    ram_re    = 1'b0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    done      = 1'b0;
    err       = 1'b0;
`ifdef STORE_UNIT_BE_EN
    ram_be    = 4'b0000;
`endif
    unique case (state_q)
      S_IDLE: begin
        req_ready = ~rst;
        if (req_valid) begin
          waddr_d = req_addr[RAM_AW+1:2];
          off_d   = req_addr[1:0];
          size_d  = req_size;
          data_d  = req_wdata;
          if (!legal) begin
            state_d = S_ERR;
          end else if (req_size == 2'b10) begin
            state_d = S_WRITE;
          end else begin
`ifdef STORE_UNIT_BE_EN
            state_d = S_WRITE;
            if (req_size == 2'b00) begin
              data_d = {4{req_wdata[7:0]}};
            end else begin
              data_d = {2{req_wdata[15:0]}};
            end
`else
            state_d = S_READ;
`endif
          end
        end
      end
      S_READ: begin
        ram_re  = ~rst;
        state_d = S_MERGE;
      end
      S_MERGE: begin
        data_d  = merged;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        ram_we    = ~rst;
        ram_wdata = data_q;
        done      = ~rst;
        state_d   = S_IDLE;
`ifdef STORE_UNIT_BE_EN
        unique case (size_q)
          2'b00:   ram_be = 4'b0001 << off_q;
          2'b01:   ram_be = off_q[1] ? 4'b1100 : 4'b0011;
          default: ram_be = 4'b1111;
        endcase
`endif
      end
      S_ERR: begin
        done    = ~rst;
        err     = ~rst;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ram_addr = waddr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      waddr_q <= '0;
      off_q   <= '0;
      size_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      off_q   <= off_d;
      size_q  <= size_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: vector table, hand sequences and random stores
// against a byte-array reference memory.
module tb_store_unit;

  localparam int AW    = 8;
  localparam int DEPTH = 256;
`ifdef STORE_UNIT_BE_EN
  localparam int SUB_LAT = 1;
  localparam int RST_AT  = 1;
`else
  localparam int SUB_LAT = 3;
  localparam int RST_AT  = 2;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic [1:0]    req_size;
  logic          done;
  logic          err;
  logic [AW-1:0] ram_addr;
  logic          ram_re;
  logic [31:0]   ram_rdata;
  logic          ram_we;
  logic [31:0]   ram_wdata;
  logic [3:0]    be_w;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  store_unit #(.RAM_AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_size  (req_size),
    .done      (done),
    .err       (err),
    .ram_addr  (ram_addr),
    .ram_re    (ram_re),
    .ram_rdata (ram_rdata),
    .ram_we    (ram_we),
`ifdef STORE_UNIT_BE_EN
    .ram_be    (be_w),
`endif
    .ram_wdata (ram_wdata)
  );

`ifndef STORE_UNIT_BE_EN
  assign be_w = 4'hF;
`endif

  // RAM behind the unit, plus a bench-side preload port.
  logic [31:0]   mem [DEPTH];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [31:0]   pre_data = '0;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    if (ram_we) begin
      for (int b = 0; b < 4; b++)
        if (be_w[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    end
    if (ram_re) ram_rdata <= mem[ram_addr];
  end

  // Reference: plain byte-addressed memory.
  logic [7:0] refb [DEPTH*4];

  function automatic logic [31:0] ref_word(input int idx);
    return {refb[idx*4+3], refb[idx*4+2],
            refb[idx*4+1], refb[idx*4]};
  endfunction

  function automatic bit is_legal(input logic [31:0] a,
                                  input logic [1:0] s);
    if (s == 2'd3) return 1'b0;
    if (s == 2'd1) return (a % 2) == 0;
    if (s == 2'd2) return (a % 4) == 0;
    return 1'b1;
  endfunction

  function automatic int exp_lat(input logic [31:0] a,
                                 input logic [1:0] s);
    if (!is_legal(a, s)) return 1;
    if (s == 2'd2) return 1;
    return SUB_LAT;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] s);
    int base;
    int n;
    base = int'(a % (DEPTH * 4));
    n = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    for (int i = 0; i < n; i++) refb[base+i] = d[i*8 +: 8];
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] w);
    @(negedge clk);
    pre_we = 1'b1;
    pre_addr = AW'(idx);
    pre_data = w;
    @(negedge clk);
    pre_we = 1'b0;
    for (int b = 0; b < 4; b++) refb[idx*4+b] = w[b*8 +: 8];
  endtask

  // Issue one request, watch until done, check the idle cycle after.
  task automatic run_req(input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] s, output int lat,
                         output bit e, output bit swe, output bit sre,
                         output logic [AW-1:0] dadr);
    bit fnd;
    fnd = 0; lat = 0; e = 0; swe = 0; sre = 0; dadr = '0;
    @(negedge clk);
    chk("ready_before", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_addr  = a;
    req_wdata = d;
    req_size  = s;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_size  = 2'($urandom);
    for (int c = 1; c <= 10 && !fnd; c++) begin
      swe |= ram_we;
      sre |= ram_re;
      if (done) begin
        fnd = 1;
        lat = c;
        e = err;
        dadr = ram_addr;
      end
      @(negedge clk);
    end
    if (!fnd) begin
      total++;
      bad++;
      $display("FAIL timeout act=no_done exp=done addr=%h", a);
    end
    chk("ready_after", {31'd0, req_ready}, 32'd1);
    chk("no_double_done", {31'd0, done}, 32'd0);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic [31:0] init;
    bit          exp_err;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vt [9];

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit e, swe, sre;
    logic [AW-1:0] dadr;
    int idx;
    int mism;
    logic [31:0] a, d;
    logic [1:0] s;

    vt[0] = '{32'h08,  32'hDEADBEEF, 2'd2, 32'h0,        0, 32'hDEADBEEF};
    vt[1] = '{32'h05,  32'h000000AB, 2'd0, 32'h11223344, 0, 32'h1122AB44};
    vt[2] = '{32'h06,  32'h0000CAFE, 2'd1, 32'h11223344, 0, 32'hCAFE3344};
    vt[3] = '{32'h03,  32'h00001234, 2'd1, 32'h55555555, 1, 32'h55555555};
    vt[4] = '{32'h0A,  32'h00001234, 2'd2, 32'h66666666, 1, 32'h66666666};
    vt[5] = '{32'h00,  32'h00001234, 2'd3, 32'h77777777, 1, 32'h77777777};
    vt[6] = '{32'h407, 32'h0000005A, 2'd0, 32'h0,        0, 32'h5A000000};
    vt[7] = '{32'h0C,  32'hFFFF1234, 2'd1, 32'h87654321, 0, 32'h87651234};
    vt[8] = '{32'h00,  32'h123456FF, 2'd0, 32'hAAAAAAAA, 0, 32'hAAAAAAFF};

    rst = 1'b1;
    req_valid = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    req_size = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_we", {31'd0, ram_we}, 32'd0);
    chk("rst_re", {31'd0, ram_re}, 32'd0);
    chk("rst_addr", {24'd0, ram_addr}, 32'd0);
    chk("rst_wdata", ram_wdata, 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_out_of_rst", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < DEPTH; i++) preload(i, $urandom);

    for (int i = 0; i < 9; i++) begin
      idx = int'(vt[i].addr[AW+1:2]);
      preload(idx, vt[i].init);
      run_req(vt[i].addr, vt[i].data, vt[i].size, lat, e, swe, sre, dadr);
      if (is_legal(vt[i].addr, vt[i].size))
        ref_store(vt[i].addr, vt[i].data, vt[i].size);
      chk($sformatf("v%0d_err", i), {31'd0, e}, {31'd0, vt[i].exp_err});
      chk($sformatf("v%0d_lat", i), lat,
          exp_lat(vt[i].addr, vt[i].size));
      chk($sformatf("v%0d_we", i), {31'd0, swe},
          {31'd0, !vt[i].exp_err});
      chk($sformatf("v%0d_re", i), {31'd0, sre},
          {31'd0, exp_lat(vt[i].addr, vt[i].size) == 3});
      chk($sformatf("v%0d_word", i), mem[idx], vt[i].exp_word);
      chk($sformatf("v%0d_model", i), mem[idx], ref_word(idx));
      if (!vt[i].exp_err)
        chk($sformatf("v%0d_addr", i), {24'd0, dadr}, idx);
    end

    // Reset while a sub-word store is in flight.
    preload(1, 32'h11223344);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr = 32'h04;
    req_wdata = 32'h00000077;
    req_size = 2'd0;
    @(negedge clk);
    req_valid = 1'b0;
    swe = 0;
    for (int c = 1; c < RST_AT; c++) begin
      swe |= ram_we | done;
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    swe |= ram_we | done;
    chk("rst_mid_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_ready_after", {31'd0, req_ready}, 32'd1);
    repeat (5) begin
      swe |= ram_we | done;
      @(negedge clk);
    end
    chk("rst_mid_no_we_done", {31'd0, swe}, 32'd0);
    chk("rst_mid_mem", mem[1], 32'h11223344);

    // Two word stores with req_valid held high.
    begin
      logic [31:0] qa [2];
      logic [31:0] qd [2];
      int acc_c [2];
      int done_c [2];
      int k, nd;
      qa[0] = 32'h0; qd[0] = 32'h1;
      qa[1] = 32'h4; qd[1] = 32'h2;
      acc_c[0] = -1; acc_c[1] = -1;
      done_c[0] = -1; done_c[1] = -1;
      k = 0; nd = 0;
      @(negedge clk);
      req_valid = 1'b1;
      req_addr = qa[0];
      req_wdata = qd[0];
      req_size = 2'd2;
      for (int c = 0; c < 20; c++) begin
        if (done) begin
          if (nd < 2) done_c[nd] = c;
          nd++;
        end
        if (req_valid && req_ready) begin
          acc_c[k] = c;
          k++;
        end
        @(negedge clk);
        if (k >= 2) begin
          req_valid = 1'b0;
        end else begin
          req_addr = qa[k];
          req_wdata = qd[k];
        end
      end
      req_valid = 1'b0;
      ref_store(qa[0], qd[0], 2'd2);
      ref_store(qa[1], qd[1], 2'd2);
      chk("b2b_done_count", nd, 2);
      chk("b2b_first_lat", done_c[0] - acc_c[0], 1);
      chk("b2b_second_accept", acc_c[1] - done_c[0], 1);
      chk("b2b_mem0", mem[0], 32'h1);
      chk("b2b_mem1", mem[1], 32'h2);
    end

    // Random requests against the byte-level model.
    for (int n = 0; n < 150; n++) begin
      a = $urandom;
      d = $urandom;
      s = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        if (s == 2'd1) a[0] = 1'b0;
        if (s == 2'd2) a[1:0] = 2'b00;
      end
      idx = int'((a / 4) % DEPTH);
      run_req(a, d, s, lat, e, swe, sre, dadr);
      if (is_legal(a, s)) ref_store(a, d, s);
      chk("rnd_err", {31'd0, e}, {31'd0, !is_legal(a, s)});
      chk("rnd_lat", lat, exp_lat(a, s));
      chk("rnd_word", mem[idx], ref_word(idx));
    end

    mism = 0;
    for (int i = 0; i < DEPTH; i++)
      if (mem[i] !== ref_word(i)) mism++;
    chk("final_mem_mismatches", mism, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
